// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 constants: register indices, exception codes, field positions
// and the default handler entry point.
package cp0_exc_unit_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam int IM_HI  = 15;
    localparam int IM_LO  = 10;
    localparam int EXL    = 1;
    localparam int IE     = 0;
    localparam int BD     = 31;
    localparam int EXC_HI = 6;
    localparam int EXC_LO = 2;

    localparam logic [31:0] CP0_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] CP0_PRID_VAL   = 32'h2023_0001;

endpackage

// File: rtl/cp0_exc_unit.sv
// M-stage coprocessor-0: merges hardware interrupts with pipeline exceptions,
// raises Req, and holds SR/Cause/EPC/PRId for mfc0/mtc0/eret.
module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = CP0_PRID_VAL,
    parameter logic [31:0] HANDLER_PC = CP0_HANDLER_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] CP0In,
    input  logic        WE,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] CP0Out,
    output logic [31:0] EPCOut,
    output logic [31:0] ExcPC,
    output logic        Req
);

    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [5:0]  ip_q;
    logic [4:0]  exc_code_q;
    logic [31:2] epc_q;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_value;
    logic [31:0] cause_value;
    logic [31:0] epc_value;
    logic        unused_vpc_low;

    assign unused_vpc_low = ^VPC[1:0];

    assign int_req = ie_q & ~exl_q & (|(HWInt & im_q));
    assign exc_req = ~exl_q & (ExcCodeIn != EXC_INT);
    assign Req     = int_req | exc_req;

    assign ExcPC     = HANDLER_PC;
    assign epc_value = {epc_q, 2'b00};
    assign EPCOut    = epc_value;

    // Req takes priority over a coincident mtc0 or eret in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            ip_q <= HWInt;
            if (Req) begin
                exl_q      <= 1'b1;
                bd_q       <= BDIn;
                exc_code_q <= int_req ? EXC_INT : ExcCodeIn;
                epc_q      <= BDIn ? (VPC[31:2] - 30'd1) : VPC[31:2];
            end else begin
                if (WE && (A2 == REG_SR)) begin
                    im_q  <= CP0In[IM_HI:IM_LO];
                    exl_q <= CP0In[EXL];
                    ie_q  <= CP0In[IE];
                end
                if (WE && (A2 == REG_EPC)) begin
                    epc_q <= CP0In[31:2];
                end
                if (EXLClr) begin
                    exl_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        sr_value              = '0;
        sr_value[IM_HI:IM_LO] = im_q;
        sr_value[EXL]         = exl_q;
        sr_value[IE]          = ie_q;

        cause_value                = '0;
        cause_value[BD]            = bd_q;
        cause_value[IM_HI:IM_LO]   = ip_q;
        cause_value[EXC_HI:EXC_LO] = exc_code_q;
    end

    always_comb begin
        CP0Out = '0;
        case (A1)
            REG_SR:    CP0Out = sr_value;
            REG_CAUSE: CP0Out = cause_value;
            REG_EPC:   CP0Out = epc_value;
            REG_PRID:  CP0Out = PRID_VAL;
            default:   CP0Out = '0;
        endcase
    end

endmodule
